// File: rtl/ppu_pkg.sv
// Shared PPU definitions: mode encoding, OAM DMA states and the memory map
// used by the VRAM/OAM responder and the PPU core.
package ppu_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } PPU_STATES_t;

  typedef logic [1:0] DMA_STATES_t;
  localparam DMA_STATES_t DMA_IDLE  = 2'd0;
  localparam DMA_STATES_t DMA_REQ   = 2'd1;
  localparam DMA_STATES_t DMA_WRITE = 2'd2;

  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] OAM_END   = 16'hFE9F;
  localparam logic [15:0] DMA_REG   = 16'hFF46;

  localparam int          VRAM_SIZE    = 8192;
  localparam int          OAM_SIZE     = 160;
  localparam logic [7:0]  OAM_LAST_IDX = 8'd159;

  // Wrap-safe window test: the offset from base is compared against the size.
  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] base,
                                    input logic [16:0] size);
    logic [15:0] off;
    off = addr - base;
    return ({1'b0, off} < size);
  endfunction

endpackage

// File: rtl/ppu_oam_dma.sv
// OAM DMA engine: copies 160 bytes from the external bus into OAM,
// one read request and one OAM write per byte (two cycles per byte).
module ppu_oam_dma
  import ppu_pkg::*;
#(
  parameter logic [15:0] DMA_REG = ppu_pkg::DMA_REG
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_data,
  output logic        dma_active,
  output logic        oam_we,
  output logic [7:0]  oam_waddr,
  output logic [7:0]  oam_wdata
);

  DMA_STATES_t state;
  logic [7:0]  idx;
  logic [7:0]  src_hi;
  logic        start;
  logic [7:0]  start_hi;
  logic [7:0]  idx_inc;

  assign start    = cpu_wr && (cpu_addr == DMA_REG);
  // Sources at E0 and above are folded down onto the C0-DF mirror.
  assign start_hi = (cpu_data >= 8'hE0) ? (cpu_data - 8'h20) : cpu_data;
  assign idx_inc  = idx + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DMA_IDLE;
      idx      <= 8'd0;
      src_hi   <= 8'd0;
      dma_rd   <= 1'b0;
      dma_addr <= 16'h0000;
    end else if (start) begin
      state    <= DMA_REQ;
      idx      <= 8'd0;
      src_hi   <= start_hi;
      dma_rd   <= 1'b1;
      dma_addr <= {start_hi, 8'h00};
    end else begin
      case (state)
        DMA_REQ: begin
          state  <= DMA_WRITE;
          dma_rd <= 1'b0;
        end
        DMA_WRITE: begin
          if (idx == OAM_LAST_IDX) begin
            state <= DMA_IDLE;
          end else begin
            idx      <= idx_inc;
            state    <= DMA_REQ;
            dma_rd   <= 1'b1;
            dma_addr <= {src_hi, idx_inc};
          end
        end
        DMA_IDLE: ;
        default: begin
          state  <= DMA_IDLE;
          dma_rd <= 1'b0;
        end
      endcase
    end
  end

  assign dma_active = (state != DMA_IDLE);
  // A restart landing on a write cycle drops the byte that was in flight.
  assign oam_we     = (state == DMA_WRITE) && !start;
  assign oam_waddr  = idx;
  assign oam_wdata  = dma_data;

endmodule

// File: rtl/ppu_vram_responder.sv
// VRAM/OAM owner: answers PPU fetches, arbitrates CPU accesses against the
// PPU mode lockout and hosts the OAM DMA engine.
module ppu_vram_responder
  import ppu_pkg::*;
#(
  parameter logic [15:0] VRAM_BASE = ppu_pkg::VRAM_BASE,
  parameter logic [15:0] OAM_BASE  = ppu_pkg::OAM_BASE,
  parameter logic [15:0] DMA_REG   = ppu_pkg::DMA_REG,
  parameter int          LOCK_EN   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ADDR,
  input  logic        WR,
  input  logic        RD,
  input  logic [7:0]  MMIO_DATA_out,
  output logic [7:0]  MMIO_DATA_in,
  input  logic [1:0]  PPU_MODE,
  input  logic        PPU_RD,
  input  logic [15:0] PPU_ADDR,
  output logic [7:0]  PPU_DATA_in,
  output logic        DMA_RD,
  output logic [15:0] DMA_ADDR,
  input  logic [7:0]  DMA_DATA,
  output logic        DMA_ACTIVE
);

  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_VRAM = 2'd1;
  localparam logic [1:0] SRC_OAM  = 2'd2;
  localparam logic [1:0] SRC_FF   = 2'd3;

  localparam logic lock_on = (LOCK_EN != 0);

  logic [7:0] vram [0:VRAM_SIZE-1];
  logic [7:0] oam  [0:OAM_SIZE-1];

  logic        cpu_vram_hit, cpu_oam_hit, ppu_vram_hit, ppu_oam_hit;
  logic [12:0] cpu_vram_idx, ppu_vram_idx;
  logic [7:0]  cpu_oam_idx, ppu_oam_idx, oam_a_idx;
  logic        vram_locked, oam_locked;
  logic        cpu_vram_rd, cpu_vram_wr, cpu_oam_rd, cpu_oam_wr;
  logic        ppu_vram_rd, ppu_oam_rd;
  logic [7:0]  ppu_vram_q, ppu_oam_q, cpu_vram_q, cpu_oam_q;
  logic [1:0]  ppu_src, cpu_src;
  logic        dma_we;
  logic [7:0]  dma_waddr, dma_wdata;

  ppu_oam_dma #(
    .DMA_REG(DMA_REG)
  ) u_dma (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_wr     (WR),
    .cpu_addr   (ADDR),
    .cpu_data   (MMIO_DATA_out),
    .dma_rd     (DMA_RD),
    .dma_addr   (DMA_ADDR),
    .dma_data   (DMA_DATA),
    .dma_active (DMA_ACTIVE),
    .oam_we     (dma_we),
    .oam_waddr  (dma_waddr),
    .oam_wdata  (dma_wdata)
  );

  assign cpu_vram_hit = in_range(ADDR, VRAM_BASE, 17'(VRAM_SIZE));
  assign cpu_oam_hit  = in_range(ADDR, OAM_BASE, 17'(OAM_SIZE));
  assign ppu_vram_hit = in_range(PPU_ADDR, VRAM_BASE, 17'(VRAM_SIZE));
  assign ppu_oam_hit  = in_range(PPU_ADDR, OAM_BASE, 17'(OAM_SIZE));

  assign cpu_vram_idx = ADDR[12:0] - VRAM_BASE[12:0];
  assign ppu_vram_idx = PPU_ADDR[12:0] - VRAM_BASE[12:0];
  assign cpu_oam_idx  = ADDR[7:0] - OAM_BASE[7:0];
  assign ppu_oam_idx  = PPU_ADDR[7:0] - OAM_BASE[7:0];

  assign vram_locked = lock_on && (PPU_MODE == DRAW);
  assign oam_locked  = lock_on && ((PPU_MODE == SCAN) || (PPU_MODE == DRAW) || DMA_ACTIVE);

  assign cpu_vram_rd = RD && cpu_vram_hit && !vram_locked;
  assign cpu_vram_wr = WR && cpu_vram_hit && !vram_locked;
  assign cpu_oam_rd  = RD && cpu_oam_hit && !oam_locked;
  assign cpu_oam_wr  = WR && cpu_oam_hit && !oam_locked;
  assign ppu_vram_rd = PPU_RD && ppu_vram_hit;
  assign ppu_oam_rd  = PPU_RD && ppu_oam_hit && !DMA_ACTIVE;

  // OAM port A is shared: DMA owns it while active, since PPU OAM reads
  // are answered with FF during that time anyway.
  assign oam_a_idx = DMA_ACTIVE ? dma_waddr : ppu_oam_idx;

  always_ff @(posedge clk) begin
    if (ppu_vram_rd) ppu_vram_q <= vram[ppu_vram_idx];
  end

  always_ff @(posedge clk) begin
    if (cpu_vram_rd) cpu_vram_q <= vram[cpu_vram_idx];
    if (cpu_vram_wr) vram[cpu_vram_idx] <= MMIO_DATA_out;
  end

  always_ff @(posedge clk) begin
    if (dma_we)          oam[oam_a_idx]   <= dma_wdata;
    else if (cpu_oam_wr) oam[cpu_oam_idx] <= MMIO_DATA_out;
    if (ppu_oam_rd) ppu_oam_q <= oam[oam_a_idx];
    if (cpu_oam_rd) cpu_oam_q <= oam[cpu_oam_idx];
  end

  // Source selects hold between accepted requests so outputs stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppu_src <= SRC_ZERO;
      cpu_src <= SRC_FF;
    end else begin
      if (PPU_RD) begin
        if (ppu_vram_hit)    ppu_src <= SRC_VRAM;
        else if (ppu_oam_rd) ppu_src <= SRC_OAM;
        else                 ppu_src <= SRC_FF;
      end
      if (RD && cpu_vram_hit)     cpu_src <= vram_locked ? SRC_FF : SRC_VRAM;
      else if (RD && cpu_oam_hit) cpu_src <= oam_locked ? SRC_FF : SRC_OAM;
    end
  end

  always_comb begin
    PPU_DATA_in = 8'hFF;
    case (ppu_src)
      SRC_ZERO: PPU_DATA_in = 8'h00;
      SRC_VRAM: PPU_DATA_in = ppu_vram_q;
      SRC_OAM:  PPU_DATA_in = ppu_oam_q;
      default:  PPU_DATA_in = 8'hFF;
    endcase
  end

  always_comb begin
    MMIO_DATA_in = 8'hFF;
    case (cpu_src)
      SRC_VRAM: MMIO_DATA_in = cpu_vram_q;
      SRC_OAM:  MMIO_DATA_in = cpu_oam_q;
      default:  MMIO_DATA_in = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_ppu_vram_responder.sv
// Directed bench for ppu_vram_responder: CPU/PPU access, lockout, OAM DMA
// (full copy, restart, source fold, reset abort).
module tb_ppu_vram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ADDR;
  logic        WR, RD;
  logic [7:0]  MMIO_DATA_out;
  logic [7:0]  MMIO_DATA_in;
  logic [1:0]  PPU_MODE;
  logic        PPU_RD;
  logic [15:0] PPU_ADDR;
  logic [7:0]  PPU_DATA_in;
  logic        DMA_RD;
  logic [15:0] DMA_ADDR;
  logic [7:0]  DMA_DATA;
  logic        DMA_ACTIVE;

  int checks = 0;
  int passed = 0;

  ppu_vram_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ADDR          (ADDR),
    .WR            (WR),
    .RD            (RD),
    .MMIO_DATA_out (MMIO_DATA_out),
    .MMIO_DATA_in  (MMIO_DATA_in),
    .PPU_MODE      (PPU_MODE),
    .PPU_RD        (PPU_RD),
    .PPU_ADDR      (PPU_ADDR),
    .PPU_DATA_in   (PPU_DATA_in),
    .DMA_RD        (DMA_RD),
    .DMA_ADDR      (DMA_ADDR),
    .DMA_DATA      (DMA_DATA),
    .DMA_ACTIVE    (DMA_ACTIVE)
  );

  always #5 clk = ~clk;

  // External bus: data one cycle after the strobe, idx ^ 5A ^ (hi - C0).
  always @(posedge clk) begin
    if (DMA_RD) DMA_DATA <= DMA_ADDR[7:0] ^ 8'h5A ^ (DMA_ADDR[15:8] - 8'hC0);
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    ADDR = a; MMIO_DATA_out = d; WR = 1'b1;
    @(negedge clk);
    WR = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    ADDR = a; RD = 1'b1;
    @(negedge clk);
    RD = 1'b0;
    d = MMIO_DATA_in;
  endtask

  task automatic ppu_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    PPU_ADDR = a; PPU_RD = 1'b1;
    @(negedge clk);
    PPU_RD = 1'b0;
    d = PPU_DATA_in;
  endtask

  // Follows a running DMA from a negedge until DMA_ACTIVE falls (bounded).
  task automatic run_dma(input bit probe, output int pulses, output int cycles,
                         output logic [15:0] first, output logic [15:0] last,
                         output int seq_err, output logic [7:0] probe_ppu,
                         output logic [7:0] probe_cpu);
    pulses = 0; cycles = 0; seq_err = 0;
    first = 16'h0000; last = 16'h0000; probe_ppu = 8'h00; probe_cpu = 8'h00;
    while (DMA_ACTIVE && cycles < 400) begin
      if (DMA_RD) begin
        if (pulses == 0) first = DMA_ADDR;
        else if (DMA_ADDR !== first + 16'(pulses)) seq_err++;
        last = DMA_ADDR;
        pulses++;
      end
      if (probe && cycles == 10) begin
        PPU_ADDR = 16'hFE05; PPU_RD = 1'b1; ADDR = 16'hFE00; RD = 1'b1;
      end
      if (probe && cycles == 11) begin
        PPU_RD = 1'b0; RD = 1'b0;
        probe_ppu = PPU_DATA_in; probe_cpu = MMIO_DATA_in;
      end
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic wait_dma_addr(input logic [15:0] a);
    int n;
    n = 0;
    while (!(DMA_RD === 1'b1 && DMA_ADDR === a) && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ADDR = 16'h0000; WR = 1'b0; RD = 1'b0; MMIO_DATA_out = 8'h00;
    PPU_MODE = 2'd0; PPU_RD = 1'b0; PPU_ADDR = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if (MMIO_DATA_in !== 8'hFF || PPU_DATA_in !== 8'h00)
      $display("FAIL reset_data: mmio=%h ppu=%h want ff/00", MMIO_DATA_in, PPU_DATA_in);
    else passed++;
    checks++;
    if (DMA_RD !== 1'b0 || DMA_ADDR !== 16'h0000 || DMA_ACTIVE !== 1'b0)
      $display("FAIL reset_dma: rd=%b addr=%h act=%b want 0/0000/0", DMA_RD, DMA_ADDR, DMA_ACTIVE);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released: mmio=%h ppu=%h", MMIO_DATA_in, PPU_DATA_in);
  endtask

  task automatic test_vram_ppu;
    logic [7:0] d;
    PPU_MODE = 2'd0;
    cpu_write(16'h8000, 8'h3C);
    ppu_read(16'h8000, d);
    checks++;
    if (d !== 8'h3C) $display("FAIL ppu_vram_rd: got %h want 3c", d);
    else passed++;
    @(negedge clk);
    checks++;
    if (PPU_DATA_in !== 8'h3C) $display("FAIL ppu_hold: got %h want 3c", PPU_DATA_in);
    else passed++;
    cpu_write(16'h8002, 8'h11);
    @(negedge clk);
    ADDR = 16'h8002; MMIO_DATA_out = 8'h77; WR = 1'b1;
    PPU_ADDR = 16'h8002; PPU_RD = 1'b1;
    @(negedge clk);
    WR = 1'b0; PPU_RD = 1'b0;
    checks++;
    if (PPU_DATA_in !== 8'h11) $display("FAIL read_before_write: got %h want 11", PPU_DATA_in);
    else passed++;
    ppu_read(16'h8002, d);
    checks++;
    if (d !== 8'h77) $display("FAIL rbw_commit: got %h want 77", d);
    else passed++;
    PPU_MODE = 2'd2;
    cpu_write(16'h9FFF, 8'hC7);
    cpu_read(16'h9FFF, d);
    checks++;
    if (d !== 8'hC7) $display("FAIL vram_top_mode2: got %h want c7", d);
    else passed++;
    $display("vram/ppu transactions done");
  endtask

  task automatic test_vram_lock;
    logic [7:0] d;
    PPU_MODE = 2'd0;
    cpu_write(16'h8001, 8'h55);
    PPU_MODE = 2'd3;
    cpu_write(16'h8001, 8'hAA);
    cpu_read(16'h8001, d);
    checks++;
    if (d !== 8'hFF) $display("FAIL vram_locked_rd: got %h want ff", d);
    else passed++;
    PPU_MODE = 2'd0;
    cpu_read(16'h8001, d);
    checks++;
    if (d !== 8'h55) $display("FAIL vram_locked_wr_dropped: got %h want 55", d);
    else passed++;
    cpu_read(16'hA000, d);
    checks++;
    if (d !== 8'h55) $display("FAIL nonowned_a000_hold: got %h want 55", d);
    else passed++;
    cpu_read(16'hFEA0, d);
    checks++;
    if (d !== 8'h55) $display("FAIL nonowned_fea0_hold: got %h want 55", d);
    else passed++;
    $display("vram lockout transactions done");
  endtask

  task automatic test_oam_lock;
    logic [7:0] d;
    PPU_MODE = 2'd1;
    cpu_write(16'hFE00, 8'h12);
    cpu_write(16'hFE01, 8'h34);
    PPU_MODE = 2'd2;
    cpu_read(16'hFE00, d);
    checks++;
    if (d !== 8'hFF) $display("FAIL oam_locked_rd: got %h want ff", d);
    else passed++;
    cpu_write(16'hFE01, 8'h99);
    PPU_MODE = 2'd1;
    cpu_read(16'hFE00, d);
    checks++;
    if (d !== 8'h12) $display("FAIL oam_rd_mode1: got %h want 12", d);
    else passed++;
    cpu_read(16'hFE01, d);
    checks++;
    if (d !== 8'h34) $display("FAIL oam_locked_wr_dropped: got %h want 34", d);
    else passed++;
    ppu_read(16'h0100, d);
    checks++;
    if (d !== 8'hFF) $display("FAIL ppu_out_of_range: got %h want ff", d);
    else passed++;
    PPU_MODE = 2'd3;
    ppu_read(16'h8000, d);
    checks++;
    if (d !== 8'h3C) $display("FAIL ppu_granted_mode3: got %h want 3c", d);
    else passed++;
    PPU_MODE = 2'd0;
    $display("oam lockout transactions done");
  endtask

  task automatic test_dma_full;
    int pulses, cycles, seq_err;
    logic [15:0] first, last;
    logic [7:0] pp, pc, d;
    PPU_MODE = 2'd0;
    cpu_write(16'hFF46, 8'hC0);
    run_dma(1'b1, pulses, cycles, first, last, seq_err, pp, pc);
    $display("dma C0: pulses=%0d cycles=%0d first=%h last=%h", pulses, cycles, first, last);
    checks++;
    if (pulses != 160 || seq_err != 0)
      $display("FAIL dma_pulses: got %0d (seq_err %0d) want 160 (0)", pulses, seq_err);
    else passed++;
    checks++;
    if (cycles != 320) $display("FAIL dma_active_len: got %0d want 320", cycles);
    else passed++;
    checks++;
    if (first !== 16'hC000 || last !== 16'hC09F)
      $display("FAIL dma_range: got %h..%h want c000..c09f", first, last);
    else passed++;
    checks++;
    if (pp !== 8'hFF || pc !== 8'hFF)
      $display("FAIL oam_busy_during_dma: ppu=%h cpu=%h want ff/ff", pp, pc);
    else passed++;
    ppu_read(16'hFE00, d);
    checks++;
    if (d !== 8'h5A) $display("FAIL oam0_c0: got %h want 5a", d);
    else passed++;
    ppu_read(16'hFE01, d);
    checks++;
    if (d !== 8'h5B) $display("FAIL oam1_c0: got %h want 5b", d);
    else passed++;
    ppu_read(16'hFE64, d);
    checks++;
    if (d !== 8'h3E) $display("FAIL oam100_c0: got %h want 3e", d);
    else passed++;
    cpu_read(16'hFE9F, d);
    checks++;
    if (d !== 8'hC5) $display("FAIL oam159_c0_cpu: got %h want c5", d);
    else passed++;
  endtask

  task automatic test_dma_restart;
    int pulses, cycles, seq_err;
    logic [15:0] first, last;
    logic [7:0] pp, pc, d;
    cpu_write(16'hFF46, 8'hC0);
    wait_dma_addr(16'hC032);
    checks++;
    if (DMA_RD !== 1'b1 || DMA_ADDR !== 16'hC032)
      $display("FAIL dma_reach_idx50: got rd=%b addr=%h want 1/c032", DMA_RD, DMA_ADDR);
    else passed++;
    ADDR = 16'hFF46; MMIO_DATA_out = 8'hD0; WR = 1'b1;
    @(negedge clk);
    WR = 1'b0;
    run_dma(1'b0, pulses, cycles, first, last, seq_err, pp, pc);
    $display("dma restart D0: pulses=%0d first=%h last=%h", pulses, first, last);
    checks++;
    if (pulses != 160 || seq_err != 0 || first !== 16'hD000 || last !== 16'hD09F)
      $display("FAIL dma_restart: got %0d %h..%h want 160 d000..d09f", pulses, first, last);
    else passed++;
    ppu_read(16'hFE00, d);
    checks++;
    if (d !== 8'h4A) $display("FAIL oam0_d0: got %h want 4a", d);
    else passed++;
    ppu_read(16'hFE9F, d);
    checks++;
    if (d !== 8'hD5) $display("FAIL oam159_d0: got %h want d5", d);
    else passed++;
    cpu_write(16'hFF46, 8'hF1);
    run_dma(1'b0, pulses, cycles, first, last, seq_err, pp, pc);
    $display("dma F1: pulses=%0d first=%h last=%h", pulses, first, last);
    checks++;
    if (first !== 16'hD100 || last !== 16'hD19F || pulses != 160)
      $display("FAIL dma_src_fold: got %h..%h (%0d) want d100..d19f (160)", first, last, pulses);
    else passed++;
    ppu_read(16'hFE50, d);
    checks++;
    if (d !== 8'h1B) $display("FAIL oam80_d1: got %h want 1b", d);
    else passed++;
  endtask

  task automatic test_reset_mid_dma;
    logic [7:0] d;
    cpu_write(16'hFF46, 8'hC3);
    wait_dma_addr(16'hC350);
    checks++;
    if (DMA_ADDR !== 16'hC350) $display("FAIL dma_reach_idx80: got %h want c350", DMA_ADDR);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (DMA_ACTIVE !== 1'b0 || DMA_RD !== 1'b0)
      $display("FAIL reset_abort: act=%b rd=%b want 0/0", DMA_ACTIVE, DMA_RD);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (MMIO_DATA_in !== 8'hFF || PPU_DATA_in !== 8'h00)
      $display("FAIL reset_mid_outputs: mmio=%h ppu=%h want ff/00", MMIO_DATA_in, PPU_DATA_in);
    else passed++;
    ppu_read(16'hFE00, d);
    checks++;
    if (d !== 8'h59) $display("FAIL oam0_kept: got %h want 59", d);
    else passed++;
    ppu_read(16'hFE4F, d);
    checks++;
    if (d !== 8'h16) $display("FAIL oam79_kept: got %h want 16", d);
    else passed++;
    ppu_read(16'hFE50, d);
    checks++;
    if (d !== 8'h1B) $display("FAIL oam80_unchanged: got %h want 1b", d);
    else passed++;
    $display("reset mid-dma transactions done");
  endtask

  initial begin
    DMA_DATA = 8'h00;
    test_reset();
    test_vram_ppu();
    test_vram_lock();
    test_oam_lock();
    test_dma_full();
    test_dma_restart();
    test_reset_mid_dma();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
